// File: rtl/axi_xbar_pkg.sv
// Shared AXI crossbar arbitration definitions: FSM state encoding,
// master count and the reset value of the round-robin pointer.
package axi_xbar_pkg;

  localparam int unsigned NUM_M = 4;
  localparam logic [3:0]  LAST_WINNER_RST = 4'b1000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } arb_state_e;

endpackage

// File: rtl/round_robin_m2s_wr_if.sv
// Write-channel arbitration bundle between the crossbar routing logic (master)
// and one per-slave write arbiter (slave).
interface round_robin_m2s_wr_if;
  import axi_xbar_pkg::*;

  logic [NUM_M-1:0] req;
  logic             aw_hs;
  logic             w_last_hs;
  logic [NUM_M-1:0] sel;
  logic             busy;

  modport master (
    output req, aw_hs, w_last_hs,
    input  sel, busy
  );

  modport slave (
    input  req, aw_hs, w_last_hs,
    output sel, busy
  );

endinterface

// File: rtl/rr_pick4.sv
// Combinational 4-way rotate-priority picker: the search starts just after the
// one-hot last_winner and wraps, so last_winner itself has lowest priority.
module rr_pick4 (
  input  logic [3:0] req,
  input  logic [3:0] last_winner,
  output logic [3:0] winner
);

  logic [1:0] lw_idx;
  logic [1:0] idx;
  logic       found;

  always_comb begin
    lw_idx = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (last_winner[i]) lw_idx = i[1:0];
    end

    winner = '0;
    idx    = '0;
    found  = 1'b0;
    // off wraps to 0 on the fourth pass, visiting last_winner last
    for (int unsigned off = 1; off <= 4; off++) begin
      idx = lw_idx + off[1:0];
      if (!found && req[idx]) begin
        winner[idx] = 1'b1;
        found       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/round_robin_m2s_wr.sv
// Per-slave AW/W arbiter: round-robin grant held until both AW handshake and
// last W beat complete. Define M2S_ARB_STATS_EN to add per-master grant counters.
module round_robin_m2s_wr #(
  parameter int unsigned NUM_M = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  round_robin_m2s_wr_if.slave     bus
`ifdef M2S_ARB_STATS_EN
  ,
  output logic [4*CNT_W-1:0]      grant_cnt
`endif
);
  import axi_xbar_pkg::*;

  if (NUM_M != 4 || CNT_W < 1) begin : g_cfg_check
    $error("round_robin_m2s_wr supports exactly 4 masters and CNT_W >= 1");
  end

  arb_state_e state_q, state_n;
  logic [3:0] sel_q;
  logic [3:0] last_winner_q;
  logic       w_done_q;
  logic [3:0] winner;
  logic       grant_now;
  logic       release_now;

  rr_pick4 u_pick (
    .req         (bus.req),
    .last_winner (last_winner_q),
    .winner      (winner)
  );

  always_comb begin
    state_n     = state_q;
    grant_now   = 1'b0;
    release_now = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.req != '0) begin
          grant_now = 1'b1;
          state_n   = ADDR;
        end
      end
      ADDR: begin
        // W may finish before AW; remember it so the AW handshake can release
        if (bus.aw_hs) begin
          if (w_done_q || bus.w_last_hs) release_now = 1'b1;
          else                           state_n     = DATA;
        end
      end
      DATA: begin
        if (bus.w_last_hs) release_now = 1'b1;
      end
      default: state_n = IDLE;
    endcase
    if (release_now) state_n = IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      sel_q         <= '0;
      last_winner_q <= LAST_WINNER_RST;
      w_done_q      <= 1'b0;
    end else begin
      state_q <= state_n;
      if (grant_now) sel_q <= winner;
      if (release_now) begin
        last_winner_q <= sel_q;
        sel_q         <= '0;
        w_done_q      <= 1'b0;
      end else if (state_q == ADDR && bus.w_last_hs && !bus.aw_hs) begin
        w_done_q <= 1'b1;
      end
    end
  end

  assign bus.sel  = sel_q;
  assign bus.busy = (state_q != IDLE);

`ifdef M2S_ARB_STATS_EN
  logic [CNT_W-1:0] cnt_q [4];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 4; i++) cnt_q[i] <= '0;
    end else if (grant_now) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (winner[i] && cnt_q[i] != '1) cnt_q[i] <= cnt_q[i] + 1'b1;
      end
    end
  end

  always_comb begin
    grant_cnt = '0;
    for (int unsigned i = 0; i < 4; i++) grant_cnt[i*CNT_W +: CNT_W] = cnt_q[i];
  end
`endif

endmodule
